mlp_sequencer: RTL and testbench
================================

# mlp_sequencer

Top-level scheduler for the MLP accelerator. It steps the (Q, N, I) index counters that the address/mode decoder consumes, so the datapath walks every input chunk, neuron and image in order. Each step waits for the adder's `adder_ready` handshake before advancing. After all layer-1 neurons of an image, it sequences the layer-2 pass, then moves to the next image and signals completion after the last one.

## Interface
- `NUM_IMG`, 10: images per run (I counts 1..NUM_IMG, ≤15).
- `NUM_NEURON`, 200: layer-1 neurons (N counts 1..NUM_NEURON, ≤255).
- `NUM_CHUNK`, 8: input chunks per layer-1 neuron (Q counts 1..NUM_CHUNK, ≤15).
- `NUM_OUT`, 10: layer-2 outputs (N counts 1..NUM_OUT in layer 2).
- `L2_CHUNK`, 2: chunks per layer-2 output (Q counts 1..L2_CHUNK).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request to begin a run; sampled only in IDLE.
- `adder_ready` input 1: accumulator has consumed the current step; sampled only in WAIT.
- `Q` output 4: chunk index.
- `N` output 8: neuron index.
- `I` output 4: image index.
- `layer` output 1: 0 = layer-1 pass, 1 = layer-2 pass.
- `step` output 1: one-cycle pulse; current Q/N/I are valid and a new MAC step begins.
- `img_done` output 1: one-cycle pulse after the last layer-2 step of an image.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last image completes.

## Operation
- Reset (asynchronous): state IDLE; Q=1, N=1, I=1; layer=0; step, img_done, busy and done all 0.
- States and transitions:
  - IDLE → ISSUE on `start`.
  - ISSUE → WAIT, always, after one cycle. `step`=1 in ISSUE.
  - WAIT holds until `adder_ready`=1, then goes to ADV.
  - ADV → ISSUE, or → DONE after the final step of the last image.
  - DONE → IDLE after one cycle. `done`=1 in DONE.
- Advance rules in ADV (counters wrap to 1, never 0):
  - Layer 0:
    - Q<NUM_CHUNK: Q+1.
    - Q=NUM_CHUNK and N<NUM_NEURON: Q=1, N+1.
    - Q=NUM_CHUNK and N=NUM_NEURON: Q=1, N=1, layer=1.
  - Layer 1:
    - Q<L2_CHUNK: Q+1.
    - Q=L2_CHUNK and N<NUM_OUT: Q=1, N+1.
    - Q=L2_CHUNK and N=NUM_OUT: Q=1, N=1, layer=0, `img_done`=1 that cycle.
      - I<NUM_IMG: I+1, next state ISSUE.
      - I=NUM_IMG: I=1, next state DONE.
- Q, N, I and layer change only in ADV. They stay stable from ISSUE through WAIT.
- `start` while busy is ignored.
- `adder_ready` outside WAIT is ignored; it is not latched.
- `adder_ready` held high continuously gives the minimum step period.
- `rst` mid-run aborts immediately to reset values. No partial-result flush.

## Timing
- `start` at edge k → ISSUE in cycle k+1 (`step`=1, busy=1).
- WAIT is entered in cycle k+2. `adder_ready` is sampled there at the earliest.
- Each step takes ISSUE + WAIT(≥1) + ADV = at least 3 cycles.
- A full run with ready always high takes 3·NUM_IMG·(NUM_NEURON·NUM_CHUNK + NUM_OUT·L2_CHUNK) + 1 (DONE) cycles after IDLE exit.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Reset and idle: assert `rst` asynchronously mid-cycle → Q=1, N=1, I=1, busy=0, step=0 immediately. With no `start`, outputs stay static for 20 cycles.
- Single image, small config (NUM_IMG=1, NUM_NEURON=3, NUM_CHUNK=2, NUM_OUT=2, L2_CHUNK=1), ready tied high:
  - Step sequence (Q,N,layer) = (1,1,0) (2,1,0) (1,2,0) (2,2,0) (1,3,0) (2,3,0) (1,1,1) (1,2,1).
  - 8 step pulses, one img_done, done 25 cycles after start.
- Backpressure: hold `adder_ready` low 7 cycles in the first WAIT → Q/N/I unchanged and no second step until ready rises. Next step follows exactly 2 cycles after the ready edge.
- Image wrap (NUM_IMG=2, small config): I goes 1→2 on the first img_done. On the second img_done, I returns to 1 and done pulses the next cycle.
- Spurious inputs: `start` pulsed while busy, and `adder_ready` pulsed during ISSUE → sequence identical to the clean run.
- Abort: assert `rst` during layer-2 WAIT, then start → full sequence restarts from (1,1,0), I=1.

Source files
------------

// File: rtl/mlp_sequencer.sv
// Top-level MLP scheduler: walks (Q, N, I) over layer-1 chunks/neurons, then the
// layer-2 pass, for every image, handshaking each MAC step with the adder.
module mlp_sequencer #(
  parameter int unsigned NUM_IMG    = 10,
  parameter int unsigned NUM_NEURON = 200,
  parameter int unsigned NUM_CHUNK  = 8,
  parameter int unsigned NUM_OUT    = 10,
  parameter int unsigned L2_CHUNK   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       adder_ready,
  output logic [3:0] Q,
  output logic [7:0] N,
  output logic [3:0] I,
  output logic       layer,
  output logic       step,
  output logic       img_done,
  output logic       busy,
  output logic       done
);

  localparam int unsigned QW = 4;
  localparam int unsigned NW = 8;
  localparam int unsigned IW = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ADV   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [QW-1:0] q_q, q_d;
  logic [NW-1:0] n_q, n_d;
  logic [IW-1:0] i_q, i_d;
  logic          layer_q, layer_d;
  logic          step_q, step_d;
  logic          img_done_q, img_done_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic q_last, n_last, img_last, run_last;

  // End-of-range detection for the current layer's chunk/neuron counters
  always_comb begin
    q_last   = layer_q ? (q_q == QW'(L2_CHUNK)) : (q_q == QW'(NUM_CHUNK));
    n_last   = layer_q ? (n_q == NW'(NUM_OUT))  : (n_q == NW'(NUM_NEURON));
    img_last = layer_q && q_last && n_last;
    run_last = img_last && (i_q == IW'(NUM_IMG));
  end

  // Next state, counter advance and registered-output decode
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    n_d     = n_q;
    i_d     = i_q;
    layer_d = layer_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (adder_ready) state_d = S_ADV;
      S_ADV: begin
        state_d = run_last ? S_DONE : S_ISSUE;
        if (!q_last) begin
          q_d = q_q + QW'(1);
        end else begin
          q_d = QW'(1);
          if (!n_last) begin
            n_d = n_q + NW'(1);
          end else begin
            n_d     = NW'(1);
            layer_d = ~layer_q;
            if (layer_q) i_d = (i_q == IW'(NUM_IMG)) ? IW'(1) : i_q + IW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are decoded from the next state so they line up with it
    step_d     = (state_d == S_ISSUE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    img_done_d = (state_d == S_ADV) && img_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      q_q        <= QW'(1);
      n_q        <= NW'(1);
      i_q        <= IW'(1);
      layer_q    <= 1'b0;
      step_q     <= 1'b0;
      img_done_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      n_q        <= n_d;
      i_q        <= i_d;
      layer_q    <= layer_d;
      step_q     <= step_d;
      img_done_q <= img_done_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Q        = q_q;
  assign N        = n_q;
  assign I        = i_q;
  assign layer    = layer_q;
  assign step     = step_q;
  assign img_done = img_done_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed bench for mlp_sequencer: two small-config instances (1 and 2 images)
// driven by shared stimulus, checked with immediate assertions.
module tb_mlp_sequencer;

  logic clk = 1'b0;
  logic rst, start, adder_ready;

  logic [3:0] o_q, t_q;
  logic [7:0] o_n, t_n;
  logic [3:0] o_i, t_i;
  logic o_layer, o_step, o_img_done, o_busy, o_done;
  logic t_layer, t_step, t_img_done, t_busy, t_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mlp_sequencer #(.NUM_IMG(1), .NUM_NEURON(3), .NUM_CHUNK(2), .NUM_OUT(2), .L2_CHUNK(1)) u_one (
    .clk(clk), .rst(rst), .start(start), .adder_ready(adder_ready),
    .Q(o_q), .N(o_n), .I(o_i), .layer(o_layer), .step(o_step),
    .img_done(o_img_done), .busy(o_busy), .done(o_done));

  mlp_sequencer #(.NUM_IMG(2), .NUM_NEURON(3), .NUM_CHUNK(2), .NUM_OUT(2), .L2_CHUNK(1)) u_two (
    .clk(clk), .rst(rst), .start(start), .adder_ready(adder_ready),
    .Q(t_q), .N(t_n), .I(t_i), .layer(t_layer), .step(t_step),
    .img_done(t_img_done), .busy(t_busy), .done(t_done));

  // Per-image step sequence {Q, N, layer}
  logic [12:0] exp_seq [8];

  logic [16:0] one_seq [16];
  logic [16:0] two_seq [16];
  int one_n, two_n, one_img, two_img, one_done_c, two_done_c, one_done_cnt, two_done_cnt;
  int two_img1, two_img2;
  logic [3:0] i_after1, i_at_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Full run with ready held high; optional stray start pulses while busy
  task automatic run_capture(input bit spurious);
    one_n = 0; two_n = 0; one_img = 0; two_img = 0;
    one_done_c = 0; two_done_c = 0; one_done_cnt = 0; two_done_cnt = 0;
    two_img1 = 0; two_img2 = 0; i_after1 = 4'hx; i_at_done = 4'hx;
    adder_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start = spurious && (c == 2 || c == 5 || c == 20);
      if (o_step) begin
        if (one_n < 16) one_seq[one_n] = {o_i, o_q, o_n, o_layer};
        one_n++;
      end
      if (t_step) begin
        if (two_n < 16) two_seq[two_n] = {t_i, t_q, t_n, t_layer};
        two_n++;
      end
      if (o_img_done) one_img++;
      if (o_done) begin one_done_cnt++; one_done_c = c; end
      if (two_img1 != 0 && c == two_img1 + 1) i_after1 = t_i;
      if (t_img_done) begin
        if (two_img == 0) two_img1 = c; else two_img2 = c;
        two_img++;
      end
      if (t_done) begin two_done_cnt++; two_done_c = c; i_at_done = t_i; end
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_one_steps"}, 32'(one_n), 32'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_one_seq%0d", tag, k), 32'(one_seq[k]), 32'({4'd1, exp_seq[k]}));
    chk({tag, "_one_img_done"}, 32'(one_img), 32'd1);
    chk({tag, "_one_done_cnt"}, 32'(one_done_cnt), 32'd1);
    chk({tag, "_one_done_cycle"}, 32'(one_done_c), 32'd25);
    chk({tag, "_two_steps"}, 32'(two_n), 32'd16);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s_two_seq%0d", tag, k), 32'(two_seq[k]),
          32'({(k < 8) ? 4'd1 : 4'd2, exp_seq[k % 8]}));
    chk({tag, "_two_img_done"}, 32'(two_img), 32'd2);
    chk({tag, "_two_img1_cycle"}, 32'(two_img1), 32'd24);
    chk({tag, "_two_i_after_img1"}, 32'(i_after1), 32'd2);
    chk({tag, "_two_img2_cycle"}, 32'(two_img2), 32'd48);
    chk({tag, "_two_done_cycle"}, 32'(two_done_c), 32'd49);
    chk({tag, "_two_i_at_done"}, 32'(i_at_done), 32'd1);
  endtask

  initial begin
    int bad;
    bit seen;
    exp_seq[0] = {4'd1, 8'd1, 1'b0};
    exp_seq[1] = {4'd2, 8'd1, 1'b0};
    exp_seq[2] = {4'd1, 8'd2, 1'b0};
    exp_seq[3] = {4'd2, 8'd2, 1'b0};
    exp_seq[4] = {4'd1, 8'd3, 1'b0};
    exp_seq[5] = {4'd2, 8'd3, 1'b0};
    exp_seq[6] = {4'd1, 8'd1, 1'b1};
    exp_seq[7] = {4'd1, 8'd2, 1'b1};

    // Reset and idle
    rst = 1'b1; start = 1'b0; adder_ready = 1'b0;
    #12 rst = 1'b0;
    chk("rst_q", 32'(o_q), 32'd1);
    chk("rst_n", 32'(o_n), 32'd1);
    chk("rst_i", 32'(o_i), 32'd1);
    chk("rst_flags", 32'({o_layer, o_step, o_img_done, o_busy, o_done}), 32'd0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if ({o_q, o_n, o_i} !== {4'd1, 8'd1, 4'd1} ||
          {o_layer, o_step, o_img_done, o_busy, o_done} !== 5'd0) bad++;
    end
    chk("idle_static", 32'(bad), 32'd0);

    // Backpressure, plus a ready pulse during ISSUE that must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bp_first_step", 32'({o_step, o_busy}), 32'b11);
    adder_ready = 1'b1;
    bad = 0;
    for (int c = 2; c <= 9; c++) begin
      @(posedge clk); #1;
      if (o_step !== 1'b0 || {o_q, o_n, o_i} !== {4'd1, 8'd1, 4'd1} || o_busy !== 1'b1) bad++;
      adder_ready = (c == 9);
    end
    chk("bp_stall", 32'(bad), 32'd0);
    @(posedge clk); #1;
    chk("bp_adv_no_step", 32'(o_step), 32'd0);
    @(posedge clk); #1;
    chk("bp_second_step", 32'({o_step, o_q, o_n}), 32'({1'b1, 4'd2, 8'd1}));
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk); #1;
      if (t_done) seen = 1'b1;
    end
    chk("bp_finish", 32'(seen), 32'd1);
    @(posedge clk); #1;

    run_capture(1'b0);
    check_run("clean");

    run_capture(1'b1);
    check_run("spur");

    // Abort during a layer-2 WAIT, then a fresh run
    start = 1'b1; adder_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (o_step && o_layer && o_n == 8'd2) begin
        seen = 1'b1;
        adder_ready = 1'b0;
      end
    end
    chk("abort_reach_l2", 32'(seen), 32'd1);
    @(posedge clk); #1;
    chk("abort_in_wait", 32'({o_busy, o_step, o_layer, o_n}), 32'({1'b1, 1'b0, 1'b1, 8'd2}));
    #2 rst = 1'b1;
    #1;
    chk("abort_async_qni", 32'({o_q, o_n, o_i, t_i}), 32'({4'd1, 8'd1, 4'd1, 4'd1}));
    chk("abort_async_flags", 32'({o_layer, o_step, o_busy, t_busy}), 32'd0);
    #3 rst = 1'b0;
    run_capture(1'b0);
    check_run("abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
